main_fsm: RTL and testbench

MAIN_FSM -- requirements
Module: main_fsm

---
 rtl/main_fsm_pkg.sv | 52 +++++
 rtl/main_fsm_imm_src_dec.sv | 20 ++
 rtl/main_fsm.sv | 166 ++++++++++++++++
 tb/tb_main_fsm.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/main_fsm_pkg.sv
// Shared constants for the multicycle control FSM: opcodes, state encoding and
// datapath mux select encodings.
package main_fsm_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    typedef enum logic [3:0] {
        StFetch,
        StDecode,
        StMemAdr,
        StMemRead,
        StMemWb,
        StMemWrite,
        StExecR,
        StExecI,
        StAluWb,
        StBranch,
        StJal,
        StLui,
        StTrap
    } state_e;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

endpackage

// File: rtl/main_fsm_imm_src_dec.sv
// Immediate format decoder: purely combinational from the latched opcode.
module imm_src_dec
    import main_fsm_pkg::*;
(
    input  logic [6:0] op,
    output logic [2:0] immsrc
);

    always_comb begin
        immsrc = IMM_I;
        case (op)
            OP_STORE:  immsrc = IMM_S;
            OP_BRANCH: immsrc = IMM_B;
            OP_JAL:    immsrc = IMM_J;
            OP_LUI:    immsrc = IMM_U;
            default:   immsrc = IMM_I;
        endcase
    end

endmodule

// File: rtl/main_fsm.sv
// Multicycle RISC-V control FSM with optional memory handshake, sticky illegal
// opcode trap and a retired-instruction counter.
module main_fsm
    import main_fsm_pkg::*;
#(
    parameter bit          TRAP_EN = 1'b1,
    parameter bit          MEM_HS  = 1'b1,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [6:0]       OP6_0,
    input  logic [2:0]       Funct3,
    input  logic             Zero,
    input  logic             MemReady,
    output logic             PCWrite,
    output logic             AdrSrc,
    output logic             MemReq,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             RegWrite,
    output logic [1:0]       ResultSrc1_0,
    output logic [1:0]       ALUSrcA1_0,
    output logic [1:0]       ALUSrcB1_0,
    output logic [1:0]       ALUOP1_0,
    output logic [2:0]       ImmSrc2_0,
    output logic             Illegal,
    output logic [CNT_W-1:0] InstRet
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] instret_q;
    logic             mem_ready, retire;
    logic             pcwrite, memreq, memwrite, irwrite, regwrite;
    logic             unused_funct3;

    assign unused_funct3 = ^Funct3[2:1];
    assign mem_ready     = MEM_HS ? MemReady : 1'b1;

    imm_src_dec u_imm_src_dec (
        .op     (OP6_0),
        .immsrc (ImmSrc2_0)
    );

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q   <= StFetch;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            if (retire) instret_q <= instret_q + CNT_W'(1);
        end
    end

    // Every completed instruction passes through one of these states on its way back to fetch.
    always_comb begin
        retire = 1'b0;
        case (state_q)
            StMemWb, StAluWb, StBranch: retire = 1'b1;
            StMemWrite:                 retire = mem_ready;
            default:                    retire = 1'b0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        pcwrite      = 1'b0;
        AdrSrc       = 1'b0;
        memreq       = 1'b0;
        memwrite     = 1'b0;
        irwrite      = 1'b0;
        regwrite     = 1'b0;
        ResultSrc1_0 = RES_ALUOUT;
        ALUSrcA1_0   = SRCA_PC;
        ALUSrcB1_0   = SRCB_RD2;
        ALUOP1_0     = ALUOP_ADD;
        unique case (state_q)
            StFetch: begin
                memreq       = 1'b1;
                ALUSrcB1_0   = SRCB_FOUR;
                ResultSrc1_0 = RES_ALURES;
                irwrite      = mem_ready;
                pcwrite      = mem_ready;
                if (mem_ready) state_d = StDecode;
            end
            StDecode: begin
                ALUSrcA1_0 = SRCA_OLDPC;
                ALUSrcB1_0 = SRCB_IMM;
                case (OP6_0)
                    OP_LOAD, OP_STORE: state_d = StMemAdr;
                    OP_RTYPE:          state_d = StExecR;
                    OP_ITYPE:          state_d = StExecI;
                    OP_BRANCH:         state_d = StBranch;
                    OP_JAL:            state_d = StJal;
                    OP_LUI:            state_d = StLui;
                    default:           state_d = TRAP_EN ? StTrap : StFetch;
                endcase
            end
            StMemAdr: begin
                ALUSrcA1_0 = SRCA_RD1;
                ALUSrcB1_0 = SRCB_IMM;
                state_d    = (OP6_0 == OP_LOAD) ? StMemRead : StMemWrite;
            end
            StMemRead: begin
                memreq = 1'b1;
                AdrSrc = 1'b1;
                if (mem_ready) state_d = StMemWb;
            end
            StMemWrite: begin
                memreq   = 1'b1;
                AdrSrc   = 1'b1;
                memwrite = 1'b1;
                if (mem_ready) state_d = StFetch;
            end
            StMemWb: begin
                ResultSrc1_0 = RES_DATA;
                regwrite     = 1'b1;
                state_d      = StFetch;
            end
            StExecR: begin
                ALUSrcA1_0 = SRCA_RD1;
                ALUOP1_0   = ALUOP_FUNCT;
                state_d    = StAluWb;
            end
            StExecI: begin
                ALUSrcA1_0 = SRCA_RD1;
                ALUSrcB1_0 = SRCB_IMM;
                ALUOP1_0   = ALUOP_FUNCT;
                state_d    = StAluWb;
            end
            StAluWb: begin
                regwrite = 1'b1;
                state_d  = StFetch;
            end
            StBranch: begin
                ALUSrcA1_0 = SRCA_RD1;
                ALUOP1_0   = ALUOP_SUB;
                pcwrite    = Zero ^ Funct3[0];
                state_d    = StFetch;
            end
            StJal: begin
                ALUSrcA1_0 = SRCA_OLDPC;
                ALUSrcB1_0 = SRCB_FOUR;
                pcwrite    = 1'b1;
                state_d    = StAluWb;
            end
            StLui: begin
                ALUSrcA1_0 = SRCA_ZERO;
                ALUSrcB1_0 = SRCB_IMM;
                state_d    = StAluWb;
            end
            StTrap: state_d = StTrap;
            default: state_d = StFetch;
        endcase
    end

    // Strobes are suppressed combinationally so a reset mid-access cancels it immediately.
    assign PCWrite  = pcwrite & RST_N;
    assign MemReq   = memreq & RST_N;
    assign MemWrite = memwrite & RST_N;
    assign IRWrite  = irwrite & RST_N;
    assign RegWrite = regwrite & RST_N;
    assign Illegal  = (state_q == StTrap);
    assign InstRet  = instret_q;

endmodule

// File: tb/tb_main_fsm.sv
// Scoreboard bench for main_fsm: default instance (trap, handshake, 32-bit count)
// and a variant (NOP on illegal, no handshake, 4-bit count).
module tb_main_fsm;

    localparam logic [6:0] L_LOAD   = 7'b0000011;
    localparam logic [6:0] L_STORE  = 7'b0100011;
    localparam logic [6:0] L_RTYPE  = 7'b0110011;
    localparam logic [6:0] L_ITYPE  = 7'b0010011;
    localparam logic [6:0] L_BRANCH = 7'b1100011;
    localparam logic [6:0] L_JAL    = 7'b1101111;
    localparam logic [6:0] L_LUI    = 7'b0110111;
    localparam logic [6:0] L_BAD    = 7'b1111111;

    localparam int P_FETCH = 0, P_DECODE = 1, P_MEMADR = 2, P_MEMREAD = 3, P_MEMWB = 4;
    localparam int P_MEMWRITE = 5, P_EXECR = 6, P_EXECI = 7, P_ALUWB = 8, P_BRANCH = 9;
    localparam int P_JAL = 10, P_LUI = 11, P_TRAP = 12;

    typedef struct packed {
        logic        pcwrite, adrsrc, memreq, memwrite, irwrite, regwrite;
        logic [1:0]  resultsrc, alusrca, alusrcb, aluop;
        logic [2:0]  immsrc;
        logic        illegal;
        logic [31:0] instret;
    } obs_t;

    logic       clk = 1'b0;
    logic       rstn [2];
    logic [6:0] op   [2];
    logic [2:0] f3   [2];
    logic       zr   [2];
    logic       mr   [2];
    logic       pcw[2], adr[2], mreq[2], mwr[2], irw[2], rgw[2], ill[2];
    logic [1:0] res[2], sra[2], srb[2], aop[2];
    logic [2:0] imm[2];
    logic [31:0] ir0;
    logic [3:0]  ir1;

    obs_t        q0[$], q1[$];
    logic [31:0] cnt [2];
    int          errors = 0, checks = 0;

    always #5 clk = ~clk;

    main_fsm dut0 (
        .CLK(clk), .RST_N(rstn[0]), .OP6_0(op[0]), .Funct3(f3[0]), .Zero(zr[0]),
        .MemReady(mr[0]), .PCWrite(pcw[0]), .AdrSrc(adr[0]), .MemReq(mreq[0]),
        .MemWrite(mwr[0]), .IRWrite(irw[0]), .RegWrite(rgw[0]), .ResultSrc1_0(res[0]),
        .ALUSrcA1_0(sra[0]), .ALUSrcB1_0(srb[0]), .ALUOP1_0(aop[0]), .ImmSrc2_0(imm[0]),
        .Illegal(ill[0]), .InstRet(ir0)
    );

    main_fsm #(.TRAP_EN(1'b0), .MEM_HS(1'b0), .CNT_W(4)) dut1 (
        .CLK(clk), .RST_N(rstn[1]), .OP6_0(op[1]), .Funct3(f3[1]), .Zero(zr[1]),
        .MemReady(mr[1]), .PCWrite(pcw[1]), .AdrSrc(adr[1]), .MemReq(mreq[1]),
        .MemWrite(mwr[1]), .IRWrite(irw[1]), .RegWrite(rgw[1]), .ResultSrc1_0(res[1]),
        .ALUSrcA1_0(sra[1]), .ALUSrcB1_0(srb[1]), .ALUOP1_0(aop[1]), .ImmSrc2_0(imm[1]),
        .Illegal(ill[1]), .InstRet(ir1)
    );

    // Control word each phase of an instruction must present, straight from the phase table.
    function automatic obs_t expect_of(input int ph, input logic rdy, input logic z,
                                       input logic [2:0] fn, input logic [6:0] o,
                                       input logic rn, input logic [31:0] c);
        obs_t e = '0;
        case (ph)
            P_FETCH:    begin e.memreq = 1; e.alusrcb = 2; e.resultsrc = 2;
                              e.irwrite = rdy; e.pcwrite = rdy; end
            P_DECODE:   begin e.alusrca = 1; e.alusrcb = 1; end
            P_MEMADR:   begin e.alusrca = 2; e.alusrcb = 1; end
            P_MEMREAD:  begin e.memreq = 1; e.adrsrc = 1; end
            P_MEMWRITE: begin e.memreq = 1; e.adrsrc = 1; e.memwrite = 1; end
            P_MEMWB:    begin e.resultsrc = 1; e.regwrite = 1; end
            P_EXECR:    begin e.alusrca = 2; e.aluop = 2; end
            P_EXECI:    begin e.alusrca = 2; e.alusrcb = 1; e.aluop = 2; end
            P_ALUWB:    e.regwrite = 1;
            P_BRANCH:   begin e.alusrca = 2; e.aluop = 1; e.pcwrite = z ^ fn[0]; end
            P_JAL:      begin e.alusrca = 1; e.alusrcb = 2; e.pcwrite = 1; end
            P_LUI:      begin e.alusrca = 3; e.alusrcb = 1; end
            P_TRAP:     e.illegal = 1;
            default:    e = '0;
        endcase
        if (!rn) begin
            e.pcwrite = 0; e.irwrite = 0; e.memwrite = 0; e.regwrite = 0; e.memreq = 0;
        end
        case (o)
            L_STORE:  e.immsrc = 3'b001;
            L_BRANCH: e.immsrc = 3'b010;
            L_JAL:    e.immsrc = 3'b011;
            L_LUI:    e.immsrc = 3'b100;
            default:  e.immsrc = 3'b000;
        endcase
        e.instret = c;
        return e;
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic cyc(input int d, input int ph, input logic drive, input logic rdy);
        obs_t e;
        mr[d] = drive;
        e = expect_of(ph, rdy, zr[d], f3[d], op[d], rstn[d], cnt[d]);
        if (d == 0) q0.push_back(e); else q1.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic retire(input int d);
        cnt[d] = (d == 0) ? cnt[d] + 1 : (cnt[d] + 1) % 16;
    endtask

    // Handshaked phase: d0 stalls for w cycles; d1 ignores MemReady entirely.
    task automatic mem_phase(input int d, input int ph, input int w);
        if (d == 0) begin
            repeat (w) cyc(d, ph, 1'b0, 1'b0);
            cyc(d, ph, 1'b1, 1'b1);
        end else begin
            cyc(d, ph, rbit(), 1'b1);
        end
    endtask

    task automatic issue(input int d, input logic [6:0] o, input logic [2:0] fn,
                         input logic z, input int wf, input int wm);
        op[d] = o; f3[d] = fn; zr[d] = z;
        mem_phase(d, P_FETCH, wf);
        cyc(d, P_DECODE, rbit(), 1'b1);
        case (o)
            L_LOAD:   begin cyc(d, P_MEMADR, rbit(), 1); mem_phase(d, P_MEMREAD, wm);
                            cyc(d, P_MEMWB, rbit(), 1); retire(d); end
            L_STORE:  begin cyc(d, P_MEMADR, rbit(), 1); mem_phase(d, P_MEMWRITE, wm);
                            retire(d); end
            L_RTYPE:  begin cyc(d, P_EXECR, rbit(), 1); cyc(d, P_ALUWB, rbit(), 1); retire(d); end
            L_ITYPE:  begin cyc(d, P_EXECI, rbit(), 1); cyc(d, P_ALUWB, rbit(), 1); retire(d); end
            L_BRANCH: begin cyc(d, P_BRANCH, rbit(), 1); retire(d); end
            L_JAL:    begin cyc(d, P_JAL, rbit(), 1); cyc(d, P_ALUWB, rbit(), 1); retire(d); end
            L_LUI:    begin cyc(d, P_LUI, rbit(), 1); cyc(d, P_ALUWB, rbit(), 1); retire(d); end
            default:  if (d == 0) repeat (20) cyc(d, P_TRAP, rbit(), 1);
        endcase
    endtask

    function automatic logic [6:0] rand_op(input bit allow_bad);
        logic [6:0] tbl [8];
        tbl[0] = L_LOAD; tbl[1] = L_STORE; tbl[2] = L_RTYPE; tbl[3] = L_ITYPE;
        tbl[4] = L_BRANCH; tbl[5] = L_JAL; tbl[6] = L_LUI; tbl[7] = L_BAD;
        return tbl[$urandom_range(0, allow_bad ? 7 : 6)];
    endfunction

    always @(negedge clk) begin
        obs_t a, e;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            a = {pcw[0], adr[0], mreq[0], mwr[0], irw[0], rgw[0], res[0], sra[0], srb[0],
                 aop[0], imm[0], ill[0], ir0};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL dut0 control word at %0t: got %h expected %h", $time, a, e);
            end
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            a = {pcw[1], adr[1], mreq[1], mwr[1], irw[1], rgw[1], res[1], sra[1], srb[1],
                 aop[1], imm[1], ill[1], 28'd0, ir1};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL dut1 control word at %0t: got %h expected %h", $time, a, e);
            end
        end
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            rstn[d] = 1'b0; op[d] = '0; f3[d] = '0; zr[d] = 1'b0; mr[d] = 1'b0; cnt[d] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        // Held in reset: fetch selects visible, all strobes suppressed.
        cyc(0, P_FETCH, 1'b1, 1'b1);
        rstn[0] = 1'b1;

        issue(0, L_LOAD, 3'b010, 1'b0, 0, 2);
        issue(0, L_BRANCH, 3'b000, 1'b1, 0, 0);
        issue(0, L_BRANCH, 3'b001, 1'b1, 1, 0);
        issue(0, L_JAL, 3'b000, 1'b0, 0, 0);
        for (int i = 0; i < 40; i++)
            issue(0, rand_op(0), 3'($urandom), rbit(), $urandom_range(0, 2), $urandom_range(0, 3));

        // Reset lands while a store is still waiting on memory.
        op[0] = L_STORE;
        cyc(0, P_FETCH, 1'b1, 1'b1);
        cyc(0, P_DECODE, 1'b0, 1'b1);
        cyc(0, P_MEMADR, 1'b0, 1'b1);
        cyc(0, P_MEMWRITE, 1'b0, 1'b0);
        rstn[0] = 1'b0;
        cyc(0, P_MEMWRITE, 1'b0, 1'b0);
        rstn[0] = 1'b1;
        cnt[0] = '0;
        for (int i = 0; i < 5; i++)
            issue(0, rand_op(0), 3'($urandom), rbit(), $urandom_range(0, 1), $urandom_range(0, 1));
        issue(0, L_BAD, 3'b000, 1'b0, 0, 0);

        cyc(1, P_FETCH, 1'b0, 1'b1);
        rstn[1] = 1'b1;
        for (int i = 0; i < 16; i++) issue(1, L_RTYPE, 3'b000, 1'b0, 0, 0);
        issue(1, L_BAD, 3'b000, 1'b0, 0, 0);
        for (int i = 0; i < 30; i++) issue(1, rand_op(1), 3'($urandom), rbit(), 0, 0);
        issue(1, L_ITYPE, 3'b000, 1'b0, 0, 0);

        @(negedge clk);
        #1;
        checks++;
        if (q0.size() + q1.size() != 0) begin
            errors++;
            $display("FAIL scoreboard drain: got %0d pending expected 0", q0.size() + q1.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
